serial_adder_inverter: RTL and testbench

- Sequential inverse of the 3-bit ripple-carry adder partition.
- Given the adder's output word {carry_out, sum} plus operand B and carry-in, recovers operand A bit-serially, LSB first, using a registered borrow.
- Used as a checker/decoder next to approximated adder partitions: feeding it the exact adder's outputs must reproduce A exactly.
- Valid/ready handshake on both sides; one operation in flight at a time.

---
 rtl/serial_adder_inverter.sv | 132 +++++++++++++
 tb/tb_serial_adder_inverter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/serial_adder_inverter.sv
// Bit-serial inverse of a ripple-carry adder: recovers A = {cout,sum} - B - cin,
// LSB first with a registered borrow, behind valid/ready handshakes.
module serial_adder_inverter #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   sum,
    input  logic [WIDTH-1:0] opb,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] opa,
    output logic             err
);

    localparam int unsigned SW    = WIDTH + 1;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q,     state_d;
    logic [SW-1:0]    sum_sh_q,    sum_sh_d;
    logic [SW-1:0]    opb_sh_q,    opb_sh_d;
    logic [SW-1:0]    res_q,       res_d;
    logic             borrow_q,    borrow_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] opa_q,       opa_d;
    logic             err_q,       err_d;

    logic [1:0]       diff;
    logic [SW-1:0]    res_next;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sum_sh_q    <= '0;
            opb_sh_q    <= '0;
            res_q       <= '0;
            borrow_q    <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            opa_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_sh_q    <= sum_sh_d;
            opb_sh_q    <= opb_sh_d;
            res_q       <= res_d;
            borrow_q    <= borrow_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            opa_q       <= opa_d;
            err_q       <= err_d;
        end
    end

    // One-bit subtract step; diff[1] set means the step went negative
    always_comb begin
        diff     = {1'b0, sum_sh_q[0]} - {1'b0, opb_sh_q[0]} - {1'b0, borrow_q};
        res_next = {diff[0], res_q[SW-1:1]};
    end

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        sum_sh_d    = sum_sh_q;
        opb_sh_d    = opb_sh_q;
        res_d       = res_q;
        borrow_d    = borrow_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        opa_d       = opa_q;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sum_sh_d   = sum;
                    opb_sh_d   = {1'b0, opb};
                    borrow_d   = cin;
                    cnt_d      = '0;
                    res_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                res_d    = res_next;
                borrow_d = diff[1];
                sum_sh_d = sum_sh_q >> 1;
                opb_sh_d = opb_sh_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    opa_d       = res_next[WIDTH-1:0];
                    err_d       = diff[1] | res_next[WIDTH];
                end
            end
            DONE: begin
                // Result held until consumed; no new accept this cycle
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign opa       = opa_q;
    assign err       = err_q;

endmodule

// File: tb/tb_serial_adder_inverter.sv
// Directed bench for serial_adder_inverter: latency, arithmetic corners,
// backpressure, mid-operation reset and an exhaustive round trip.
module tb_serial_adder_inverter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] sum;
    logic [2:0] opb;
    logic       cin;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] opa;
    logic       err;

    int checks = 0;
    int errors = 0;

    serial_adder_inverter #(.WIDTH(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .opb       (opb),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .opa       (opa),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, check exact latency, hold for 'stall' cycles, then drain
    task automatic do_op(input logic [3:0] s, input logic [2:0] b, input logic c,
                         input logic [2:0] exp_opa, input logic exp_err, input int stall);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        sum      = s;
        opb      = b;
        cin      = c;
        tick();
        in_valid = 1'b0;
        sum      = 4'($urandom);
        opb      = 3'($urandom);
        cin      = 1'($urandom);
        chk("busy_in_ready", 32'(in_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("early_out_valid", 32'(out_valid), 32'd0);
        end
        tick();
        chk("out_valid_latency", 32'(out_valid), 32'd1);
        chk("opa", 32'(opa), 32'(exp_opa));
        chk("err", 32'(err), 32'(exp_err));
        chk("done_in_ready", 32'(in_ready), 32'd0);
        for (int k = 0; k < stall; k++) begin
            out_ready = 1'b0;
            in_valid  = 1'($urandom);
            sum       = 4'($urandom);
            opb       = 3'($urandom);
            cin       = 1'($urandom);
            tick();
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_opa", 32'(opa), 32'(exp_opa));
            chk("stall_err", 32'(err), 32'(exp_err));
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("handshake_out_valid", 32'(out_valid), 32'd0);
        chk("handshake_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sum       = '0;
        opb       = '0;
        cin       = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_opa", 32'(opa), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // Arithmetic corners
        do_op(4'b0111, 3'd5, 1'b0, 3'd2, 1'b0, 0);
        do_op(4'b1101, 3'd7, 1'b1, 3'd5, 1'b0, 0);
        do_op(4'b1111, 3'd7, 1'b1, 3'd7, 1'b0, 0);
        do_op(4'd2,    3'd3, 1'b0, 3'd7, 1'b1, 0);
        do_op(4'b1111, 3'd0, 1'b0, 3'd7, 1'b1, 0);

        // Backpressure with ignored in_valid pulses
        do_op(4'd9, 3'd2, 1'b1, 3'd6, 1'b0, 5);

        // Reset in the middle of SHIFT discards the operation
        in_valid = 1'b1;
        sum      = 4'd10;
        opb      = 3'd3;
        cin      = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("midrst_no_out_valid", 32'(out_valid), 32'd0);
        end
        do_op(4'd10, 3'd3, 1'b0, 3'd7, 1'b0, 0);

        // Exhaustive round trip
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                for (int c = 0; c < 2; c++) begin
                    do_op(4'(a + b + c), 3'(b), 1'(c), 3'(a), 1'b0,
                          int'($urandom_range(0, 2)));
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
